cv32e40p_x_result_buf: RTL and testbench

- Result-side companion to the x-interface dispatcher.
- Accepts offloaded-instruction results from the accelerator result channel and buffers them in a small FIFO.
- Drains results into the core register-file write port whenever the core's own writeback is idle.
- Emits the per-result completion pulse (x_rvalid / x_rwaddr) that the dispatcher uses to clear its scoreboard.

---
 rtl/cv32e40p_x_result_buf_if.sv | 25 ++
 rtl/cv32e40p_x_result_buf.sv | 100 ++++++++++
 tb/tb_cv32e40p_x_result_buf.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_x_result_buf_if.sv
// Accelerator result channel plus regfile write / completion channel of the x-interface result buffer.
// The slave modport is the buffer's view; the master modport is the environment's view.
interface cv32e40p_x_result_buf_if;
  logic        x_result_valid_i;
  logic        x_result_ready_o;
  logic        x_result_we_i;
  logic [4:0]  x_result_rd_i;
  logic [31:0] x_result_data_i;
  logic        core_wb_busy_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        x_rvalid_o;
  logic [4:0]  x_rwaddr_o;

  modport slave (
    input  x_result_valid_i, x_result_we_i, x_result_rd_i, x_result_data_i, core_wb_busy_i,
    output x_result_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, x_rvalid_o, x_rwaddr_o
  );

  modport master (
    output x_result_valid_i, x_result_we_i, x_result_rd_i, x_result_data_i, core_wb_busy_i,
    input  x_result_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, x_rvalid_o, x_rwaddr_o
  );
endinterface

// File: rtl/cv32e40p_x_result_buf.sv
// Buffers accelerator results in a small FIFO and drains them into the regfile write port when the core is idle.
// Optional macro X_RESULT_BYPASS_EN lets a result reach the write port in its arrival cycle when the FIFO is empty.
module cv32e40p_x_result_buf #(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cv32e40p_x_result_buf_if.slave x_if,
  output logic                   empty_o,
  output logic [CNT_W-1:0]       count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Handshake: a result transfers on a clock edge where x_result_valid_i and
  // x_result_ready_o are both high; ready is a function of registered occupancy only.
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_ready;
  logic w_empty;
  logic w_hs;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_out_vld;
  logic [4:0]  w_out_rd;
  logic [31:0] w_out_data;

  assign w_ready = (r_count != FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_hs    = x_if.x_result_valid_i & w_ready;

`ifdef X_RESULT_BYPASS_EN
  assign w_bypass = w_hs & x_if.x_result_we_i & w_empty & ~x_if.core_wb_busy_i;
`else
  assign w_bypass = 1'b0;
`endif

  // Results without a writeback are accepted and dropped; bypassed results never occupy an entry.
  assign w_push = w_hs & x_if.x_result_we_i & ~w_bypass;
  assign w_pop  = ~w_empty & ~x_if.core_wb_busy_i;

  always_comb begin
    w_out_vld  = 1'b0;
    w_out_rd   = '0;
    w_out_data = '0;
    if (w_pop) begin
      w_out_vld  = 1'b1;
      w_out_rd   = r_rd[r_rd_ptr];
      w_out_data = r_data[r_rd_ptr];
    end else if (w_bypass) begin
      w_out_vld  = 1'b1;
      w_out_rd   = x_if.x_result_rd_i;
      w_out_data = x_if.x_result_data_i;
    end
  end

  // x0 results still complete toward the dispatcher but must not write the regfile.
  assign x_if.rf_we_o          = w_out_vld & (w_out_rd != 5'd0);
  assign x_if.rf_waddr_o       = w_out_rd;
  assign x_if.rf_wdata_o       = w_out_data;
  assign x_if.x_rvalid_o       = w_out_vld;
  assign x_if.x_rwaddr_o       = w_out_rd;
  assign x_if.x_result_ready_o = w_ready;
  assign empty_o               = w_empty;
  assign count_o               = r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_rd[r_wr_ptr]   <= x_if.x_result_rd_i;
        r_data[r_wr_ptr] <= x_if.x_result_data_i;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_x_result_buf.sv
// Self-checking bench for cv32e40p_x_result_buf: directed scenarios plus a random run
// scoreboarded against an independent occupancy model and an expected-result queue.
module tb_cv32e40p_x_result_buf;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic empty_o;
  logic [CNT_W-1:0] count_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [36:0] exp_q[$];
  int          m_cnt = 0;
  logic        m_ready;
  logic        m_hs;
  logic        m_byp;
  logic        m_pop;
  logic        m_vld;
  logic [36:0] m_e;

  cv32e40p_x_result_buf_if x_if ();

  cv32e40p_x_result_buf #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .x_if    (x_if),
    .empty_o (empty_o),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: expected results are queued on every accepted writeback and
  // popped whenever a completion is due.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      m_ready = (m_cnt != DEPTH);
      n_tests++;
      if (x_if.x_result_ready_o !== m_ready) begin
        n_fail++;
        $display("FAIL sb_ready got %b exp %b", x_if.x_result_ready_o, m_ready);
      end
      n_tests++;
      if (count_o !== CNT_W'(m_cnt) || empty_o !== (m_cnt == 0)) begin
        n_fail++;
        $display("FAIL sb_count got cnt=%0d empty=%b exp cnt=%0d", count_o, empty_o, m_cnt);
      end
      m_hs  = x_if.x_result_valid_i & m_ready;
      m_byp = 1'b0;
`ifdef X_RESULT_BYPASS_EN
      m_byp = m_hs & x_if.x_result_we_i & (m_cnt == 0) & ~x_if.core_wb_busy_i;
`endif
      if (m_hs && x_if.x_result_we_i) exp_q.push_back({x_if.x_result_rd_i, x_if.x_result_data_i});
      m_pop = (m_cnt != 0) && !x_if.core_wb_busy_i;
      m_vld = m_pop | m_byp;
      n_tests++;
      if (x_if.x_rvalid_o !== m_vld) begin
        n_fail++;
        $display("FAIL sb_rvalid got %b exp %b", x_if.x_rvalid_o, m_vld);
      end else if (m_vld) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow got completion rd=%0d exp none", x_if.x_rwaddr_o);
        end else begin
          m_e = exp_q.pop_front();
          if (x_if.x_rwaddr_o !== m_e[36:32] || x_if.rf_waddr_o !== m_e[36:32] ||
              x_if.rf_wdata_o !== m_e[31:0] || x_if.rf_we_o !== (m_e[36:32] != 5'd0)) begin
            n_fail++;
            $display("FAIL sb_result got rd=%0d waddr=%0d data=%h we=%b exp rd=%0d data=%h we=%b",
                     x_if.x_rwaddr_o, x_if.rf_waddr_o, x_if.rf_wdata_o, x_if.rf_we_o,
                     m_e[36:32], m_e[31:0], (m_e[36:32] != 5'd0));
          end
        end
      end else begin
        if (x_if.rf_we_o !== 1'b0 || x_if.rf_waddr_o !== 5'd0 ||
            x_if.rf_wdata_o !== 32'd0 || x_if.x_rwaddr_o !== 5'd0) begin
          n_fail++;
          $display("FAIL sb_idle got we=%b waddr=%0d data=%h rwaddr=%0d exp all zero",
                   x_if.rf_we_o, x_if.rf_waddr_o, x_if.rf_wdata_o, x_if.x_rwaddr_o);
        end
      end
      m_cnt = m_cnt + ((m_hs && x_if.x_result_we_i && !m_byp) ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
    x_if.x_result_valid_i = v;
    x_if.x_result_we_i    = we;
    x_if.x_result_rd_i    = rd;
    x_if.x_result_data_i  = d;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    x_if.core_wb_busy_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    n_tests++; if (x_if.x_result_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", x_if.x_result_ready_o); end
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty_o); end
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count_o); end
    n_tests++; if (x_if.rf_we_o !== 1'b0 || x_if.x_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got we=%b rvalid=%b exp 0", x_if.rf_we_o, x_if.x_rvalid_o); end
    n_tests++; if (x_if.rf_waddr_o !== 5'd0 || x_if.x_rwaddr_o !== 5'd0 || x_if.rf_wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_bus got waddr=%0d rwaddr=%0d data=%h exp 0", x_if.rf_waddr_o, x_if.x_rwaddr_o, x_if.rf_wdata_o); end
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    x_if.core_wb_busy_i = 1'b0;
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
`ifdef X_RESULT_BYPASS_EN
    @(negedge clk);
    n_tests++; if (x_if.rf_we_o !== 1'b1 || x_if.rf_waddr_o !== 5'd5 || x_if.rf_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_byp got we=%b waddr=%0d data=%h exp 1/5/deadbeef", x_if.rf_we_o, x_if.rf_waddr_o, x_if.rf_wdata_o); end
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
`else
    @(negedge clk);
    n_tests++; if (x_if.x_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_early got rvalid=%b exp 0", x_if.x_rvalid_o); end
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_tests++; if (x_if.rf_we_o !== 1'b1 || x_if.rf_waddr_o !== 5'd5 || x_if.rf_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wb got we=%b waddr=%0d data=%h exp 1/5/deadbeef", x_if.rf_we_o, x_if.rf_waddr_o, x_if.rf_wdata_o); end
    n_tests++; if (x_if.x_rvalid_o !== 1'b1 || x_if.x_rwaddr_o !== 5'd5) begin n_fail++; $display("FAIL single_cpl got rvalid=%b rwaddr=%0d exp 1/5", x_if.x_rvalid_o, x_if.x_rwaddr_o); end
    step();
`endif
    @(negedge clk);
    n_tests++; if (empty_o !== 1'b1 || x_if.x_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_empty got empty=%b rvalid=%b exp 1/0", empty_o, x_if.x_rvalid_o); end
    step();
  endtask

  task automatic test_back_to_back();
    x_if.core_wb_busy_i = 1'b1;
    drive(1'b1, 1'b1, 5'd1, 32'h11);
    step();
    drive(1'b1, 1'b1, 5'd2, 32'h22);
    step();
    drive(1'b1, 1'b1, 5'd3, 32'h33);
    @(negedge clk);
    n_tests++; if (count_o !== 2'd2 || x_if.x_result_ready_o !== 1'b0) begin n_fail++; $display("FAIL busy_full got cnt=%0d ready=%b exp 2/0", count_o, x_if.x_result_ready_o); end
    step();
    @(negedge clk);
    n_tests++; if (count_o !== 2'd2 || x_if.x_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL busy_hold got cnt=%0d rvalid=%b exp 2/0", count_o, x_if.x_rvalid_o); end
    step();
    x_if.core_wb_busy_i = 1'b0;
    @(negedge clk);
    n_tests++; if (x_if.x_rwaddr_o !== 5'd1 || x_if.rf_wdata_o !== 32'h11) begin n_fail++; $display("FAIL drain_1 got rd=%0d data=%h exp 1/11", x_if.x_rwaddr_o, x_if.rf_wdata_o); end
    step();
    @(negedge clk);
    n_tests++; if (x_if.x_rwaddr_o !== 5'd2 || count_o !== 2'd1 || x_if.x_result_ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_2 got rd=%0d cnt=%0d ready=%b exp 2/1/1", x_if.x_rwaddr_o, count_o, x_if.x_result_ready_o); end
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_tests++; if (x_if.x_rwaddr_o !== 5'd3 || x_if.rf_wdata_o !== 32'h33) begin n_fail++; $display("FAIL drain_3 got rd=%0d data=%h exp 3/33", x_if.x_rwaddr_o, x_if.rf_wdata_o); end
    step();
    @(negedge clk);
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", empty_o); end
    step();
  endtask

  task automatic test_x0();
    x_if.core_wb_busy_i = 1'b0;
    drive(1'b1, 1'b1, 5'd0, 32'h1234);
`ifndef X_RESULT_BYPASS_EN
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
`endif
    @(negedge clk);
    n_tests++; if (x_if.x_rvalid_o !== 1'b1 || x_if.x_rwaddr_o !== 5'd0 || x_if.rf_we_o !== 1'b0) begin n_fail++; $display("FAIL x0 got rvalid=%b rwaddr=%0d we=%b exp 1/0/0", x_if.x_rvalid_o, x_if.x_rwaddr_o, x_if.rf_we_o); end
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_we0();
    x_if.core_wb_busy_i = 1'b0;
    drive(1'b1, 1'b0, 5'd9, 32'hCAFE);
    @(negedge clk);
    n_tests++; if (x_if.x_result_ready_o !== 1'b1 || x_if.x_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL we0_hs got ready=%b rvalid=%b exp 1/0", x_if.x_result_ready_o, x_if.x_rvalid_o); end
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_tests++; if (count_o !== 2'd0 || x_if.x_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL we0_drop got cnt=%0d rvalid=%b exp 0/0", count_o, x_if.x_rvalid_o); end
    step();
  endtask

  task automatic test_full_pop_reset();
    x_if.core_wb_busy_i = 1'b1;
    drive(1'b1, 1'b1, 5'd10, 32'hA0);
    step();
    drive(1'b1, 1'b1, 5'd11, 32'hB0);
    step();
    x_if.core_wb_busy_i = 1'b0;
    drive(1'b1, 1'b1, 5'd12, 32'hC0);
    @(negedge clk);
    n_tests++; if (x_if.x_result_ready_o !== 1'b0 || count_o !== 2'd2 || x_if.x_rwaddr_o !== 5'd10) begin n_fail++; $display("FAIL fullpop_refuse got ready=%b cnt=%0d rd=%0d exp 0/2/10", x_if.x_result_ready_o, count_o, x_if.x_rwaddr_o); end
    step();
    @(negedge clk);
    n_tests++; if (count_o !== 2'd1 || x_if.x_result_ready_o !== 1'b1 || x_if.x_rwaddr_o !== 5'd11) begin n_fail++; $display("FAIL fullpop_next got cnt=%0d ready=%b rd=%0d exp 1/1/11", count_o, x_if.x_result_ready_o, x_if.x_rwaddr_o); end
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    n_tests++; if (x_if.rf_we_o !== 1'b1 || count_o !== 2'd1) begin n_fail++; $display("FAIL prerst got we=%b cnt=%0d exp 1/1", x_if.rf_we_o, count_o); end
    #1;
    rst_i = 1'b1;
    #1;
    n_tests++; if (count_o !== 2'd0 || x_if.rf_we_o !== 1'b0 || x_if.x_result_ready_o !== 1'b1 || empty_o !== 1'b1 || x_if.x_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL midrst got cnt=%0d we=%b ready=%b empty=%b rvalid=%b exp 0/0/1/1/0", count_o, x_if.rf_we_o, x_if.x_result_ready_o, empty_o, x_if.x_rvalid_o); end
    step();
    rst_i = 1'b0;
    @(negedge clk);
    n_tests++; if (count_o !== 2'd0 || x_if.x_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL postrst got cnt=%0d rvalid=%b exp 0/0", count_o, x_if.x_rvalid_o); end
    step();
  endtask

`ifdef X_RESULT_BYPASS_EN
  task automatic test_bypass();
    x_if.core_wb_busy_i = 1'b0;
    drive(1'b1, 1'b1, 5'd7, 32'h55);
    @(negedge clk);
    n_tests++; if (x_if.rf_we_o !== 1'b1 || x_if.rf_waddr_o !== 5'd7 || x_if.rf_wdata_o !== 32'h55 || count_o !== 2'd0) begin n_fail++; $display("FAIL bypass got we=%b waddr=%0d data=%h cnt=%0d exp 1/7/55/0", x_if.rf_we_o, x_if.rf_waddr_o, x_if.rf_wdata_o, count_o); end
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_tests++; if (count_o !== 2'd0 || empty_o !== 1'b1 || x_if.x_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL bypass_after got cnt=%0d empty=%b rvalid=%b exp 0/1/0", count_o, empty_o, x_if.x_rvalid_o); end
    step();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      x_if.core_wb_busy_i = ($urandom_range(0, 2) == 0);
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)), $urandom);
      step();
    end
    x_if.core_wb_busy_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    repeat (4) step();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_leftover got %0d pending exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_x0();
    test_we0();
    test_full_pop_reset();
`ifdef X_RESULT_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
